ptw_sched: RTL and testbench

PTW_SCHED -- requirements
Module: ptw_sched

---
 rtl/mmu_pkg.sv | 26 ++
 rtl/ptw_sched.sv | 120 ++++++++++++
 tb/tb_ptw_sched.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
// Shared MMU types: TLB<->PTW request/response payloads and the walk
// scheduler state encoding.
package mmu_pkg;

  localparam int VPN_SIZE = 27;

  typedef struct packed {
    logic [VPN_SIZE-1:0] vpn;
    logic [1:0]          prv;
    logic                store;
    logic                fetch;
  } tlb_ptw_req_t;

  typedef struct packed {
    logic        error;
    logic [1:0]  level;
    logic [63:0] pte;
  } ptw_tlb_resp_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_RESP = 2'd2
  } ptw_state_e;

endpackage

// File: rtl/ptw_sched.sv
// Arbitrates iTLB/dTLB miss requests onto a single page-table walker and
// routes the walker's response back to the TLB that owns the walk.
module ptw_sched
  import mmu_pkg::*;
(
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          itlb_req_valid_i,
  input  tlb_ptw_req_t  itlb_req_i,
  output logic          itlb_req_ready_o,
  output logic          itlb_resp_valid_o,
  input  logic          dtlb_req_valid_i,
  input  tlb_ptw_req_t  dtlb_req_i,
  output logic          dtlb_req_ready_o,
  output logic          dtlb_resp_valid_o,
  output ptw_tlb_resp_t tlb_resp_o,
  output logic          ptw_req_valid_o,
  output tlb_ptw_req_t  ptw_req_o,
  input  logic          ptw_ready_i,
  input  logic          ptw_resp_valid_i,
  input  ptw_tlb_resp_t ptw_resp_i,
  input  logic          flush_i,
  output logic          grant_owner_o
);

  localparam int NUM_REQ = 2;

  ptw_state_e                r_state, w_state_nxt;
  logic [NUM_REQ-1:0]        w_req_valid, w_req_ready, w_pend_valid, w_resp_valid;
  tlb_ptw_req_t [NUM_REQ-1:0] w_req_in, w_pend_req;
  logic                      r_owner, r_ptr, r_squash;
  logic                      w_grant, w_winner, w_walk_done;
  ptw_tlb_resp_t             r_tlb_resp;

  assign w_req_valid = {dtlb_req_valid_i, itlb_req_valid_i};
  assign w_req_in[0] = itlb_req_i;
  assign w_req_in[1] = dtlb_req_i;

  assign w_walk_done = (r_state == S_WALK) && ptw_resp_valid_i;

  // Index 0 = iTLB, 1 = dTLB
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_buf
    logic         r_vld;
    tlb_ptw_req_t r_req;

    assign w_req_ready[k]  = !r_vld && !flush_i;
    assign w_pend_valid[k] = r_vld;
    assign w_pend_req[k]   = r_req;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_vld <= 1'b0;
        r_req <= '0;
      end else if (flush_i) begin
        r_vld <= 1'b0;
      end else if (w_req_valid[k] && w_req_ready[k]) begin
        r_vld <= 1'b1;
        r_req <= w_req_in[k];
      end else if (w_walk_done && (r_owner == 1'(k))) begin
        r_vld <= 1'b0;
      end
    end
  end

  // Sole pending requester wins outright; the pointer only breaks ties.
  assign w_winner = (&w_pend_valid) ? r_ptr : w_pend_valid[1];
  assign w_grant  = (r_state == S_IDLE) && (|w_pend_valid) && ptw_ready_i && !flush_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_WALK;
      S_WALK:  if (ptw_resp_valid_i) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A flush landing in S_RESP itself must also kill that cycle's strobe.
  always_comb begin
    ptw_req_valid_o = 1'b0;
    w_resp_valid    = '0;
    case (r_state)
      S_IDLE:  ptw_req_valid_o = w_grant;
      S_RESP:  w_resp_valid[r_owner] = !(r_squash || flush_i);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_owner    <= 1'b0;
      r_ptr      <= 1'b0;
      r_squash   <= 1'b0;
      r_tlb_resp <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_winner;
        r_ptr   <= ~w_winner;
      end
      if (r_state == S_RESP)                      r_squash <= 1'b0;
      else if (flush_i && (r_state == S_WALK))    r_squash <= 1'b1;
      if (w_walk_done) r_tlb_resp <= ptw_resp_i;
    end
  end

  assign ptw_req_o         = w_pend_req[w_winner];
  assign itlb_req_ready_o  = w_req_ready[0];
  assign dtlb_req_ready_o  = w_req_ready[1];
  assign itlb_resp_valid_o = w_resp_valid[0];
  assign dtlb_resp_valid_o = w_resp_valid[1];
  assign tlb_resp_o        = r_tlb_resp;
  assign grant_owner_o     = r_owner;

endmodule

// File: tb/tb_ptw_sched.sv
// Scoreboard bench for ptw_sched: expected issues/responses are queued as
// stimulus is driven and retired by a negedge monitor.
module tb_ptw_sched;
  import mmu_pkg::*;

  logic          clk = 1'b0, rstn = 1'b0;
  logic          itlb_req_valid_i = 1'b0, dtlb_req_valid_i = 1'b0;
  tlb_ptw_req_t  itlb_req_i = '0, dtlb_req_i = '0;
  logic          itlb_req_ready_o, dtlb_req_ready_o, itlb_resp_valid_o, dtlb_resp_valid_o;
  ptw_tlb_resp_t tlb_resp_o;
  logic          ptw_req_valid_o;
  tlb_ptw_req_t  ptw_req_o;
  logic          ptw_ready_i = 1'b1, ptw_resp_valid_i = 1'b0, flush_i = 1'b0;
  ptw_tlb_resp_t ptw_resp_i = '0;
  logic          grant_owner_o;

  ptw_sched dut (
    .clk_i(clk), .rstn_i(rstn),
    .itlb_req_valid_i(itlb_req_valid_i), .itlb_req_i(itlb_req_i),
    .itlb_req_ready_o(itlb_req_ready_o), .itlb_resp_valid_o(itlb_resp_valid_o),
    .dtlb_req_valid_i(dtlb_req_valid_i), .dtlb_req_i(dtlb_req_i),
    .dtlb_req_ready_o(dtlb_req_ready_o), .dtlb_resp_valid_o(dtlb_resp_valid_o),
    .tlb_resp_o(tlb_resp_o), .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_o(ptw_req_o),
    .ptw_ready_i(ptw_ready_i), .ptw_resp_valid_i(ptw_resp_valid_i), .ptw_resp_i(ptw_resp_i),
    .flush_i(flush_i), .grant_owner_o(grant_owner_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          src;
    logic        err;
    logic [1:0]  lvl;
    logic [63:0] pte;
    int          cyc;
  } exp_resp_t;

  exp_resp_t           exp_resp[$];
  logic [VPN_SIZE-1:0] exp_issue[$];
  int                  n_chk = 0, n_fail = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic req(input bit src, input logic [VPN_SIZE-1:0] vpn);
    tlb_ptw_req_t r;
    r = '0; r.vpn = vpn; r.prv = 2'b01; r.fetch = !src;
    if (src) begin
      chk("d_ready", dtlb_req_ready_o, 1);
      dtlb_req_valid_i = 1'b1; dtlb_req_i = r;
    end else begin
      chk("i_ready", itlb_req_ready_o, 1);
      itlb_req_valid_i = 1'b1; itlb_req_i = r;
    end
    exp_issue.push_back(vpn);
  endtask

  task automatic clr();
    itlb_req_valid_i = 1'b0; dtlb_req_valid_i = 1'b0; #1;
  endtask

  // Called in S_WALK; returns in S_IDLE one cycle after the response strobe.
  task automatic walker_resp(input bit src, input bit vis, input logic err,
                             input logic [1:0] lvl, input logic [63:0] pte);
    exp_resp_t e;
    ptw_resp_valid_i = 1'b1;
    ptw_resp_i.error = err; ptw_resp_i.level = lvl; ptw_resp_i.pte = pte;
    e.src = src; e.err = err; e.lvl = lvl; e.pte = pte; e.cyc = cyc + 1;
    if (vis) exp_resp.push_back(e);
    step();
    ptw_resp_valid_i = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    logic [VPN_SIZE-1:0] v;
    exp_resp_t e;
    if (ptw_req_valid_o) begin
      if (exp_issue.size() == 0) chk("issue_unexp", 1, 0);
      else begin
        v = exp_issue.pop_front();
        chk("issue_vpn", ptw_req_o.vpn, v);
      end
    end
    if (itlb_resp_valid_o && dtlb_resp_valid_o) chk("resp_excl", 1, 0);
    if (itlb_resp_valid_o || dtlb_resp_valid_o) begin
      if (exp_resp.size() == 0) chk("resp_unexp", 1, 0);
      else begin
        e = exp_resp.pop_front();
        chk("resp_src", dtlb_resp_valid_o, e.src);
        chk("resp_owner", grant_owner_o, e.src);
        chk("resp_err", tlb_resp_o.error, e.err);
        chk("resp_lvl", tlb_resp_o.level, e.lvl);
        chk("resp_pte", tlb_resp_o.pte, e.pte);
        chk("resp_lat", cyc, e.cyc);
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_i_ready"}, itlb_req_ready_o, 1);
    chk({tag, "_d_ready"}, dtlb_req_ready_o, 1);
    chk({tag, "_i_rv"}, itlb_resp_valid_o, 0);
    chk({tag, "_d_rv"}, dtlb_resp_valid_o, 0);
    chk({tag, "_issue"}, ptw_req_valid_o, 0);
    chk({tag, "_resp"}, tlb_resp_o, 0);
    chk({tag, "_owner"}, grant_owner_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    step(); step();
    chk_reset("rst");
    rstn = 1'b1;
    step();

    // Simultaneous requests: iTLB first, then dTLB after the 2-cycle gap
    req(0, 27'h0A0A0A); req(1, 27'h0B0B0B);
    step(); clr();
    chk("t1_issue_i", ptw_req_valid_o, 1);
    step();
    chk("t1_walk_quiet", ptw_req_valid_o, 0);
    step();
    walker_resp(0, 1, 1'b0, 2'd2, 64'h1111_2222_3333_4444);
    chk("t1_issue_d", ptw_req_valid_o, 1);
    step();
    walker_resp(1, 1, 1'b0, 2'd0, 64'h5555_6666_7777_8888);

    // dTLB alone, back-to-back
    for (int i = 0; i < 3; i++) begin
      req(1, 27'h100 + 27'(i));
      step(); clr();
      chk("t2_issue", ptw_req_valid_o, 1);
      step();
      walker_resp(1, 1, 1'b0, 2'(i), 64'hABC0 + 64'(i));
    end

    // Flush mid-walk squashes the response; request under flush is rejected
    req(0, 27'h0C0C0C);
    step(); clr();
    step(); step();
    flush_i = 1'b1; dtlb_req_valid_i = 1'b1; dtlb_req_i.vpn = 27'h0DEAD; #1;
    chk("t3_d_ready_flush", dtlb_req_ready_o, 0);
    step();
    flush_i = 1'b0; dtlb_req_valid_i = 1'b0; #1;
    chk("t3_i_empty", itlb_req_ready_o, 1);
    chk("t3_d_empty", dtlb_req_ready_o, 1);
    walker_resp(0, 0, 1'b0, 2'd0, 64'hBAD);
    chk("t3_no_issue", ptw_req_valid_o, 0);
    req(1, 27'h0E0E0E);
    step(); clr();
    chk("t3_reissue", ptw_req_valid_o, 1);
    step();
    walker_resp(1, 1, 1'b0, 2'd1, 64'h0E0E);

    // Walker busy for 10 cycles with both pending
    ptw_ready_i = 1'b0;
    req(0, 27'h0F0F0F); req(1, 27'h121212);
    step(); clr();
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold", ptw_req_valid_o, 0);
      chk("t4_d_busy", dtlb_req_ready_o, 0);
      step();
    end
    ptw_ready_i = 1'b1; #1;
    chk("t4_issue_i", ptw_req_valid_o, 1);
    step();
    walker_resp(0, 1, 1'b0, 2'd2, 64'h0F0F);
    chk("t4_issue_d", ptw_req_valid_o, 1);
    step();
    walker_resp(1, 1, 1'b0, 2'd2, 64'h1212);

    // Reset mid-walk; late walker response afterwards is ignored
    req(1, 27'h131313);
    step(); clr();
    step();
    chk("t5_owner", grant_owner_o, 1);
    rstn = 1'b0; #1;
    chk_reset("t5");
    step(); step();
    rstn = 1'b1;
    step();
    ptw_resp_valid_i = 1'b1; ptw_resp_i = '{error: 1'b1, level: 2'd3, pte: 64'hFFFF};
    step();
    ptw_resp_valid_i = 1'b0;
    step(); step();
    chk("t5_resp_ignored", tlb_resp_o, 0);
    chk("t5_idle", ptw_req_valid_o, 0);

    // Error response with level 1
    req(0, 27'h141414);
    step(); clr();
    step();
    walker_resp(0, 1, 1'b1, 2'd1, 64'h0000_0000_2000_00CF);
    chk("t6_err", tlb_resp_o.error, 1);
    chk("t6_lvl", tlb_resp_o.level, 1);

    step(); step();
    chk("issue_q_empty", exp_issue.size(), 0);
    chk("resp_q_empty", exp_resp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
